// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out UART receiver: start, 8 data bits LSB first, optional parity, stop.
// Bits are sampled mid-period using an oversampling tick from the baud generator.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       reg_clk,
  input  logic       reg_rst,
  input  logic       sample_tick,
  input  logic       serial_in,
  output logic [7:0] p_data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam bit HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          perr_q;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      perr_q     <= 1'b0;
      p_data_out <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        // A start bit that is high again at its midpoint was only a glitch
        START: begin
          if (sample_tick) begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (tick_cnt == TICK_LAST) begin
              shift_reg <= {rx_s, shift_reg[7:1]};
              tick_cnt  <= '0;
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state <= HAS_PARITY ? PARITY : STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample_tick) begin
            if (tick_cnt == TICK_LAST) begin
              perr_q   <= (^shift_reg) ^ rx_s ^ ODD_BIT;
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        // A low stop bit parks in BREAK so a held-low line reports only once
        STOP: begin
          if (sample_tick) begin
            if (tick_cnt == TICK_LAST) begin
              p_data_out <= shift_reg;
              parity_err <= HAS_PARITY ? perr_q : 1'b0;
              frame_err  <= ~rx_s;
              data_valid <= 1'b1;
              tick_cnt   <= '0;
              state      <= rx_s ? IDLE : BREAK;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: table-driven frames, corner-case sequences,
// and randomized back-to-back frames checked against a frame-level reference model.
module tb_uart_rx_sipo;

  localparam int OVERSAMPLE = 16;
  localparam int PARITY_EN  = 1;
  localparam int PARITY_ODD = 0;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

  logic       reg_clk;
  logic       reg_rst;
  logic       sample_tick;
  logic       serial_in;
  logic [7:0] p_data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_sipo #(
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .reg_clk    (reg_clk),
    .reg_rst    (reg_rst),
    .sample_tick(sample_tick),
    .serial_in  (serial_in),
    .p_data_out (p_data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  rx_t  got_q[$];
  rx_t  exp_q[$];
  vec_t vecs[5];
  int   n_checks;
  int   n_fail;
  int   dv_run;
  int   long_strobes;

  initial begin
    reg_clk = 1'b0;
    forever #5 reg_clk = ~reg_clk;
  end

  // Baud generator stand-in: one-cycle tick every TICK_DIV clocks
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge reg_clk);
      sample_tick = 1'b1;
      @(negedge reg_clk);
      sample_tick = 1'b0;
    end
  end

  // Collect every strobe and flag any strobe wider than one cycle
  always @(negedge reg_clk) begin
    rx_t r;
    if (data_valid === 1'b1) begin
      r.d  = p_data_out;
      r.pe = parity_err;
      r.fe = frame_err;
      got_q.push_back(r);
      dv_run = dv_run + 1;
      if (dv_run > 1) long_strobes = long_strobes + 1;
    end else begin
      dv_run = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkFrame(input string name, input logic [7:0] d, input logic pe, input logic fe);
    rx_t r;
    if (got_q.size() == 0) begin
      checkOutput({name, "_present"}, 32'd0, 32'd1);
    end else begin
      r = got_q.pop_front();
      checkOutput({name, "_data"}, {24'd0, r.d}, {24'd0, d});
      checkOutput({name, "_perr"}, {31'd0, r.pe}, {31'd0, pe});
      checkOutput({name, "_ferr"}, {31'd0, r.fe}, {31'd0, fe});
    end
  endtask

  task automatic driveBit(input logic b, input int clks);
    serial_in = b;
    repeat (clks) @(negedge reg_clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic pbit, input logic stop);
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) driveBit(d[i], BIT_CLKS);
    driveBit(pbit, BIT_CLKS);
    driveBit(stop, BIT_CLKS);
    serial_in = 1'b1;
  endtask

  function automatic logic model_perr(input logic [7:0] d, input logic pbit);
    int ones;
    ones = pbit;
    for (int i = 0; i < 8; i++) ones += d[i];
    return ((ones % 2) != PARITY_ODD);
  endfunction

  initial begin
    logic busy_seen;
    logic [7:0] rd;
    logic rp, rs;
    rx_t e;
    int n_rand;

    n_checks = 0;
    n_fail = 0;
    dv_run = 0;
    long_strobes = 0;
    serial_in = 1'b1;
    reg_rst = 1'b1;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

    repeat (3) @(negedge reg_clk);
    reg_rst = 1'b0;
    repeat (100) @(negedge reg_clk);
    $display("[TB] reset state");
    checkOutput("rst_data", {24'd0, p_data_out}, 32'd0);
    checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("rst_perr", {31'd0, parity_err}, 32'd0);
    checkOutput("rst_ferr", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_strobes", got_q.size(), 32'd0);

    $display("[TB] table frames");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data, vecs[v].pbit, vecs[v].stop);
      repeat (2 * BIT_CLKS) @(negedge reg_clk);
      checkOutput($sformatf("vec%0d_count", v), got_q.size(), 32'd1);
      checkFrame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
      checkOutput($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
      got_q.delete();
    end

    $display("[TB] start glitch");
    busy_seen = 1'b0;
    serial_in = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV; i++) begin
      @(negedge reg_clk);
      if (busy) busy_seen = 1'b1;
    end
    serial_in = 1'b1;
    for (int i = 0; i < 3 * BIT_CLKS; i++) begin
      @(negedge reg_clk);
      if (busy) busy_seen = 1'b1;
    end
    checkOutput("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    checkOutput("glitch_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("glitch_strobes", got_q.size(), 32'd0);
    checkOutput("glitch_data_held", {24'd0, p_data_out}, 32'h80);
    checkOutput("glitch_ferr_held", {31'd0, frame_err}, 32'd1);

    $display("[TB] break line");
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) driveBit(rd_bit(8'h3C, i), BIT_CLKS);
    driveBit(1'b0, BIT_CLKS);
    driveBit(1'b0, 21 * BIT_CLKS);
    checkOutput("break_busy", {31'd0, busy}, 32'd1);
    checkOutput("break_count", got_q.size(), 32'd1);
    serial_in = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge reg_clk);
    checkOutput("break_idle", {31'd0, busy}, 32'd0);
    checkFrame("break", 8'h3C, 1'b0, 1'b1);
    applyStimulus(8'h55, 1'b0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge reg_clk);
    checkOutput("after_break_count", got_q.size(), 32'd1);
    checkFrame("after_break", 8'h55, 1'b0, 1'b0);
    got_q.delete();

    $display("[TB] reset mid-frame");
    driveBit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) driveBit(1'b1, BIT_CLKS);
    driveBit(1'b1, BIT_CLKS / 2);
    reg_rst = 1'b1;
    @(negedge reg_clk);
    reg_rst = 1'b0;
    serial_in = 1'b1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_data", {24'd0, p_data_out}, 32'd0);
    checkOutput("midrst_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("midrst_perr", {31'd0, parity_err}, 32'd0);
    checkOutput("midrst_ferr", {31'd0, frame_err}, 32'd0);
    repeat (3 * BIT_CLKS) @(negedge reg_clk);
    checkOutput("midrst_strobes", got_q.size(), 32'd0);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge reg_clk);
    checkOutput("ff_count", got_q.size(), 32'd1);
    checkFrame("ff", 8'hFF, 1'b0, 1'b0);
    got_q.delete();

    $display("[TB] random back-to-back frames");
    n_rand = 14;
    for (int i = 0; i < n_rand; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      e.d = rd;
      e.pe = model_perr(rd, rp);
      e.fe = ~rs;
      exp_q.push_back(e);
      applyStimulus(rd, rp, rs);
      if (!rs) driveBit(1'b1, BIT_CLKS);
    end
    repeat (2 * BIT_CLKS) @(negedge reg_clk);
    checkOutput("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < n_rand; i++) begin
      e = exp_q.pop_front();
      checkFrame($sformatf("rand%0d", i), e.d, e.pe, e.fe);
    end

    checkOutput("strobe_width", long_strobes, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] d, input int i);
    return d[i];
  endfunction

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
Serial-in/parallel-out UART receiver. It is the receive-side counterpart of the team's PISO transmit register. It recovers frames of the form start(0), 8 data bits LSB first, optional parity bit, stop(1) from an asynchronous serial line, using an oversampling tick from the baud generator. Each received byte is presented with a one-cycle valid strobe and parity/framing status for the UART host interface.

Parameters:
OVERSAMPLE, 16, sample_tick pulses per bit period; power of two, at least 8; tick counter width is log2(OVERSAMPLE).
PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit is expected.
PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit equals 0); 1 = odd parity (XOR equals 1).

Ports:
reg_clk  input  1  system clock; all logic is on the rising edge.
reg_rst  input  1  synchronous, active-high reset.
sample_tick  input  1  one-reg_clk-cycle enable at OVERSAMPLE x baud rate.
serial_in  input  1  asynchronous RX line; idles high.
p_data_out  output  8  last received byte; held until the next frame completes.
data_valid  output  1  one-cycle strobe when p_data_out, parity_err and frame_err update.
parity_err  output  1  parity mismatch on the last frame; 0 when PARITY_EN=0.
frame_err  output  1  stop bit sampled low on the last frame.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Synchronizer: serial_in passes through 2 flops (reset value 1). rx_s denotes the second flop. All sampling uses rx_s.
- Reset (reg_rst=1 at a clock edge): state=IDLE; tick_cnt=0; bit_cnt=0; shift reg=0; p_data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0. Reset mid-frame aborts the frame immediately and produces no data_valid.
- Counters advance only on cycles with sample_tick=1. Without ticks, all state holds. data_valid is forced to 0 on every cycle except the strobe cycle.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: treat as a glitch and return to IDLE with no strobe.
- DATA: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE-1 (mid-bit):
  - Shift right with rx_s into bit 7; tick_cnt wraps to 0; bit_cnt++.
  - After the 8th bit (bit_cnt 7->0 wrap), go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: on the mid-bit tick, latch perr = ((^shift) ^ rx_s) != PARITY_ODD, then go to STOP with tick_cnt=0.
- STOP: on the mid-bit tick, in the next reg_clk cycle:
  - Load p_data_out from the shift reg.
  - Load parity_err = perr (0 if PARITY_EN=0) and frame_err = ~rx_s.
  - Pulse data_valid for exactly 1 cycle.
  - Next state: rx_s=1 -> IDLE; rx_s=0 -> BREAK.
- Latency: data_valid asserts 1 reg_clk after the stop-bit mid-bit tick.
- BREAK: wait until rx_s=1 (tick not required), then go to IDLE. No new start bit is detected while the line stays low, so a held-low line yields exactly one frame_err strobe.
- Status outputs keep their values until the next data_valid. They are cleared only by reset.
- A start edge arriving one tick after the stop sample is accepted normally; back-to-back frames have no dead time beyond the half stop bit.

Test Plan:
(All scenarios use OVERSAMPLE=16, PARITY_EN=1, PARITY_ODD=0, and sample_tick every 4 reg_clk.)
1. Reset with the line idle high for 100 cycles -> all outputs 0, busy=0, no data_valid.
2. Send 0xA5 with parity bit 0 and stop 1 -> a single one-cycle data_valid; p_data_out=0xA5; parity_err=0; frame_err=0; busy=0 afterwards.
3. Send 0x01 with parity bit 0 (wrong) -> data_valid; p_data_out=0x01; parity_err=1; frame_err=0. Then send 0x03 with parity 0 -> parity_err returns to 0.
4. Pull the line low for 4 ticks, then high -> busy pulses high then returns to 0; no data_valid; outputs unchanged.
5. Send 0x3C with stop bit 0 and hold the line low for 20 bit times -> exactly one data_valid with p_data_out=0x3C and frame_err=1. Then release the line high and send 0x55 correctly -> p_data_out=0x55, frame_err=0.
6. Assert reg_rst for 1 cycle during the 4th data bit -> all outputs 0, busy=0, no strobe. Then send a full 0xFF frame (parity 0) -> p_data_out=0xFF, no errors.
